// File: rtl/fpu_addsub_pipe_if.sv
// Streaming operand/result bundle for fpu_addsub_pipe.
// Word layout is {sign, exponent, mantissa}; the width is derived from EXP_W and MAN_W.
interface fpu_addsub_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [1:0]   warning;

  modport master (
    output in_valid, op_sub, a_in, b_in, out_ready,
    input  in_ready, out_valid, result, warning
  );

  modport slave (
    input  in_valid, op_sub, a_in, b_in, out_ready,
    output in_ready, out_valid, result, warning
  );
endinterface

// File: rtl/fpu_addsub_pipe.sv
// Four-stage floating-point adder/subtractor with global-stall valid/ready streaming.
// Define FPU_ADDSUB_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fpu_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic              clk,
  input logic              rst_n,
  fpu_addsub_pipe_if.slave bus
);
  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned SumW = MAN_W + 5;
  localparam int          ExpMax = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] ExpOnes = '1;
  localparam logic [W-1:0] Qnan = {1'b0, ExpOnes, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             spc;
    logic [W-1:0]     spc_res;
    logic [1:0]       spc_warn;
    logic             sign;
    logic [EXP_W-1:0] exp;
  } ctl_t;

  logic v1, v2, v3, v4, stall;
  ctl_t s1_ctl, s1_ctl_d, s2_ctl, s3_ctl;
  logic [MAN_W:0] s1_man_l, s1_man_l_d, s1_man_s, s1_man_s_d, s2_man_l;
  logic [EXP_W-1:0] s1_diff, s1_diff_d;
  logic s1_sub, s1_sub_d, s2_sub;
  logic [MAN_W+3:0] s2_man_s, s2_man_s_d;
  logic [SumW-1:0] s3_sum, s3_sum_d;
  logic [W-1:0] res_q, res_d;
  logic [1:0] warn_q, warn_d;

  assign stall         = v4 & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = v4;
  assign bus.result    = res_q;
  assign bus.warning   = warn_q;

  // S1: unpack, classify specials, order operands by magnitude.
  logic sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_big;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic [EXP_W+MAN_W-1:0] mag_a, mag_b;

  always_comb begin
    sa     = bus.a_in[W-1];
    sb     = bus.b_in[W-1] ^ bus.op_sub;
    ea     = bus.a_in[W-2:MAN_W];
    eb     = bus.b_in[W-2:MAN_W];
    ma     = bus.a_in[MAN_W-1:0];
    mb     = bus.b_in[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_nan  = (ea == ExpOnes) && (ma != '0);
    b_nan  = (eb == ExpOnes) && (mb != '0);
    a_inf  = (ea == ExpOnes) && (ma == '0);
    b_inf  = (eb == ExpOnes) && (mb == '0);
    mag_a  = a_zero ? '0 : {ea, ma};
    mag_b  = b_zero ? '0 : {eb, mb};
    a_big  = (mag_a >= mag_b);

    s1_ctl_d = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      s1_ctl_d.spc      = 1'b1;
      s1_ctl_d.spc_res  = Qnan;
      s1_ctl_d.spc_warn = 2'b11;
    end else if (a_inf || b_inf) begin
      s1_ctl_d.spc     = 1'b1;
      s1_ctl_d.spc_res = {a_inf ? sa : sb, ExpOnes, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      s1_ctl_d.spc     = 1'b1;
      s1_ctl_d.spc_res = {sa & sb, {(W-1){1'b0}}};
    end
    s1_ctl_d.sign = a_big ? sa : sb;
    s1_ctl_d.exp  = a_big ? ea : eb;
    s1_man_l_d    = a_big ? {~a_zero, mag_a[MAN_W-1:0]} : {~b_zero, mag_b[MAN_W-1:0]};
    s1_man_s_d    = a_big ? {~b_zero, mag_b[MAN_W-1:0]} : {~a_zero, mag_a[MAN_W-1:0]};
    s1_diff_d     = a_big ? (ea - eb) : (eb - ea);
    s1_sub_d      = sa ^ sb;
  end

  // S2: align the smaller mantissa into {hidden, man, G, R, S}.
  logic [31:0] d_ext;
  logic [2*MAN_W+3:0] w2, sh;

  always_comb begin
    d_ext      = 32'(s1_diff);
    w2         = {s1_man_s, {(MAN_W+3){1'b0}}};
    sh         = w2 >> d_ext;
    s2_man_s_d = '0;
    if (d_ext >= MAN_W + 3) begin
      s2_man_s_d[0] = |s1_man_s;
    end else begin
      s2_man_s_d = {sh[2*MAN_W+3:MAN_W+1], |sh[MAN_W:0]};
    end
  end

  // S3: magnitude add/subtract; |A| >= |B| keeps the difference non-negative.
  always_comb begin
    if (s2_sub) begin
      s3_sum_d = {1'b0, s2_man_l, 3'b000} - {1'b0, s2_man_s};
    end else begin
      s3_sum_d = {1'b0, s2_man_l, 3'b000} + {1'b0, s2_man_s};
    end
  end

  // S4: normalise, round, pack.
  int lz, en, en_r;
  logic found;
  logic [MAN_W+3:0] nm;
  logic [MAN_W-1:0] man;
`ifdef FPU_ADDSUB_RNE_EN
  logic [MAN_W+1:0] mr;
`else
  logic unused_nm;
  assign unused_nm = ^{nm[MAN_W+3], nm[2:0]};
`endif

  always_comb begin
    lz    = 0;
    found = 1'b0;
    for (int i = MAN_W + 3; i >= 0; i--) begin
      if (!found) begin
        if (s3_sum[i]) found = 1'b1;
        else lz++;
      end
    end
    if (s3_sum[SumW-1]) begin
      nm = {s3_sum[SumW-1:2], s3_sum[1] | s3_sum[0]};
      en = int'(s3_ctl.exp) + 1;
    end else begin
      nm = s3_sum[MAN_W+3:0] << lz;
      en = int'(s3_ctl.exp) - lz;
    end
    en_r = en;
`ifdef FPU_ADDSUB_RNE_EN
    mr  = {1'b0, nm[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, nm[2] & (nm[1] | nm[0] | nm[3])};
    man = mr[MAN_W-1:0];
    if (mr[MAN_W+1]) begin
      en_r = en + 1;
      man  = mr[MAN_W:1];
    end
`else
    man = nm[MAN_W+2:3];
`endif
    warn_d = 2'b00;
    if (s3_ctl.spc) begin
      res_d  = s3_ctl.spc_res;
      warn_d = s3_ctl.spc_warn;
    end else if (s3_sum == '0) begin
      res_d = '0;
    end else if (en < 1) begin
      res_d  = {s3_ctl.sign, {(W-1){1'b0}}};
      warn_d = 2'b10;
    end else if (en_r >= ExpMax) begin
      res_d  = {s3_ctl.sign, ExpOnes, {MAN_W{1'b0}}};
      warn_d = 2'b01;
    end else begin
      res_d = {s3_ctl.sign, en_r[EXP_W-1:0], man};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1, v2, v3, v4} <= '0;
      s1_ctl   <= '0;
      s1_man_l <= '0;
      s1_man_s <= '0;
      s1_diff  <= '0;
      s1_sub   <= 1'b0;
      s2_ctl   <= '0;
      s2_man_l <= '0;
      s2_man_s <= '0;
      s2_sub   <= 1'b0;
      s3_ctl   <= '0;
      s3_sum   <= '0;
      res_q    <= '0;
      warn_q   <= '0;
    end else if (!stall) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      if (bus.in_valid) begin
        s1_ctl   <= s1_ctl_d;
        s1_man_l <= s1_man_l_d;
        s1_man_s <= s1_man_s_d;
        s1_diff  <= s1_diff_d;
        s1_sub   <= s1_sub_d;
      end
      if (v1) begin
        s2_ctl   <= s1_ctl;
        s2_man_l <= s1_man_l;
        s2_man_s <= s2_man_s_d;
        s2_sub   <= s1_sub;
      end
      if (v2) begin
        s3_ctl <= s2_ctl;
        s3_sum <= s3_sum_d;
      end
      if (v3) begin
        res_q  <= res_d;
        warn_q <= warn_d;
      end
    end
  end
endmodule

// File: doc/fpu_addsub_pipe.md
Name: fpu_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor.
- Next generation of the single-precision addition unit: configurable exponent and mantissa widths, add/sub mode, valid/ready streaming, and a 2-bit warning code.
- Sits between CNN datapath producers, such as MAC accumulators, and result buffers.
- Accepts one operation per cycle when not stalled.

Parameters:
- EXP_W, 8, exponent field width (≥3).
- MAN_W, 23, stored mantissa width (≥2); total word width W = 1+EXP_W+MAN_W (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept this cycle
- op_sub  in  1  0: a_in+b_in, 1: a_in−b_in
- a_in  in  W  operand A {sign, exp, man}
- b_in  in  W  operand B
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- result  out  W  packed result
- warning  out  2  00 none, 01 overflow, 10 underflow, 11 invalid

Behaviour:
- Reset: all stage valid bits cleared. out_valid=0, result=0, warning=00, in_ready=1 one cycle after rst_n release. Asynchronous assertion mid-operation discards all in-flight ops; nothing emerges after release.
- Transfer rules:
  - Input transfer on in_valid&in_ready.
  - Output transfer on out_valid&out_ready.
  - result and warning held stable while out_valid&!out_ready.
- Pipeline: 4 stages, latency 4 cycles from input transfer to out_valid (no stall).
  - S1: unpack, apply op_sub to B sign, compare magnitudes, swap so |A|≥|B|, exponent difference.
  - S2: align smaller mantissa (hidden bit restored) with guard/round/sticky. Shift ≥ MAN_W+3 leaves only sticky.
  - S3: add or subtract magnitudes (MAN_W+5 bits incl. carry).
  - S4: leading-zero normalise, round, pack, warning.
- Stall: global. stall = out_valid & !out_ready; in_ready = !stall. On stall every stage holds. Bubbles do not compress.
- Full throughput (1/cycle) when out_ready held high.
- Zero/denormal inputs: exp==0 treated as ±0 (flush, no warning).
- Special cases:
  - NaN in, or inf−inf (effective) → canonical qNaN {0, all-ones, 1 then zeros}, warning 11.
  - inf ± finite → that inf, 00.
  - Exact zero from cancellation → +0.
  - (−0)+(−0) → −0.
- Overflow: post-round exponent ≥ all-ones → signed inf, warning 01.
- Underflow: normalised exponent < 1 → signed zero, warning 10.
- Rounding per Optional Feature. Mantissa carry-out from rounding renormalises (exp+1, may overflow).

Optional Feature:
- Macro FPU_ADDSUB_RNE_EN.
- Defined: round-to-nearest-even using guard/round/sticky.
- Undefined: truncation (round toward zero); G/R/S discarded, S4 rounding incrementer omitted.
- Latency and interface identical in both builds.

Test Plan:
- 0x3F800000 + 0x40000000, op_sub=0 → 0x40400000, warning 00, out_valid exactly 4 cycles after accept. Then 0x40400000 − 0x40400000 (op_sub=1) → 0x00000000, 00.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, 01. 0x7F800000 + 0xFF800000 → 0x7FC00000, 11. 0x7FC00001 + 0x3F800000 → 0x7FC00000, 11.
- 0x00800001 − 0x00800000 → 0x00000000, 10.
- Rounding:
  - 0x3F800000 + 0x33C00000 → 0x3F800001 with FPU_ADDSUB_RNE_EN, 0x3F800000 without.
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000 in both builds.
- Backpressure: stream 8 random pairs with out_ready low for cycles 3–9. in_ready low exactly while out_valid&!out_ready; all 8 results emerge in order, match golden model, and stay stable while stalled.
- Reset: assert rst_n=0 with 3 ops in flight. out_valid drops immediately, no stale result after release. The next op completes normally with latency 4.
